// File: rtl/mips16_control_fsm.sv
// Multi-cycle main control FSM for the 16-bit MIPS-style processor (Moore outputs).
// Optional HALT state is built only when CTRL_HALT_EN is defined; otherwise opcode 1111 runs as R-type.
module mips16_control_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic [3:0] funct,
    output logic [1:0] PCsrc,
    output logic       IorD,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       IRwrite,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUsrcA,
    output logic [2:0] ALUsrcB,
    output logic [1:0] ALUdir,
    output logic       MemToReg,
    output logic       PCWrite,
    output logic       branch,
    output logic       be,
    output logic [3:0] cur_state,
    output logic       done_sig
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXR    = 4'd2,
        S_RWB    = 4'd3,
        S_EXSH   = 4'd4,
        S_EXI    = 4'd5,
        S_MADDR  = 4'd6,
        S_MRD    = 4'd7,
        S_MWB    = 4'd8,
        S_MWR    = 4'd9,
        S_BR     = 4'd10,
        S_JMP    = 4'd11,
        S_JR     = 4'd12
`ifdef CTRL_HALT_EN
        ,
        S_HALT   = 4'd13
`endif
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_nop;
    logic [1:0] w_pcsrc;
    logic       w_iord;
    logic       w_memwrite;
    logic       w_memread;
    logic       w_irwrite;
    logic       w_regdst;
    logic       w_regwrite;
    logic       w_alusrca;
    logic [2:0] w_alusrcb;
    logic [1:0] w_aludir;
    logic       w_memtoreg;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_be;
    logic       w_done;

    assign w_nop = (opcode == 4'b1000) && (funct == 4'b0000);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    4'b1000:                   w_next = w_nop ? S_RWB : S_EXR;
                    4'b1100, 4'b0001, 4'b0010: w_next = S_EXR;
                    4'b1011:                   w_next = S_EXSH;
                    4'b1001, 4'b1010,
                    4'b0110, 4'b0111:          w_next = S_EXI;
                    4'b1101, 4'b1110:          w_next = S_MADDR;
                    4'b0100, 4'b0101:          w_next = S_BR;
                    4'b0011:                   w_next = S_JMP;
                    4'b0000:                   w_next = S_JR;
`ifdef CTRL_HALT_EN
                    4'b1111:                   w_next = S_HALT;
`else
                    4'b1111:                   w_next = S_EXR;
`endif
                    default:                   w_next = S_FETCH;
                endcase
            end
            S_EXR, S_EXSH, S_EXI: w_next = S_RWB;
            S_MADDR: begin
                if (opcode == 4'b1101) begin
                    w_next = S_MRD;
                end else if (opcode == 4'b1110) begin
                    w_next = S_MWR;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MRD:    w_next = S_MWB;
`ifdef CTRL_HALT_EN
            S_HALT:   w_next = S_HALT;
`endif
            default:  w_next = S_FETCH;
        endcase
    end

    // Moore output decode; only RWB and BR look at the held instruction fields
    always_comb begin
        w_pcsrc    = 2'b00;
        w_iord     = 1'b0;
        w_memwrite = 1'b0;
        w_memread  = 1'b0;
        w_irwrite  = 1'b0;
        w_regdst   = 1'b0;
        w_regwrite = 1'b0;
        w_alusrca  = 1'b0;
        w_alusrcb  = 3'b000;
        w_aludir   = 2'b00;
        w_memtoreg = 1'b0;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_be       = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_memread = 1'b1;
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                w_pcsrc   = 2'b10;
                w_alusrcb = 3'b001;
            end
            S_DECODE: w_alusrcb = 3'b010;
            S_EXR: begin
                w_alusrca = 1'b1;
                w_aludir  = 2'b10;
            end
            S_EXSH: begin
                w_alusrca = 1'b1;
                w_alusrcb = 3'b011;
                w_aludir  = 2'b10;
            end
            S_EXI: begin
                w_alusrca = 1'b1;
                w_alusrcb = 3'b100;
                w_aludir  = 2'b11;
            end
            S_RWB: begin
                w_regwrite = ~w_nop;
                w_regdst   = (opcode == 4'b0001) || (opcode == 4'b0010);
                w_done     = 1'b1;
            end
            S_MADDR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 3'b100;
            end
            S_MRD: begin
                w_memread = 1'b1;
                w_iord    = 1'b1;
            end
            S_MWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_MWR: begin
                w_memwrite = 1'b1;
                w_iord     = 1'b1;
                w_done     = 1'b1;
            end
            S_BR: begin
                w_alusrca = 1'b1;
                w_aludir  = 2'b01;
                w_branch  = 1'b1;
                w_be      = ~opcode[0];
                w_done    = 1'b1;
            end
            S_JMP: begin
                w_pcwrite = 1'b1;
                w_done    = 1'b1;
            end
            S_JR: begin
                w_pcwrite = 1'b1;
                w_pcsrc   = 2'b01;
                w_done    = 1'b1;
            end
            default: w_done = 1'b0;
        endcase
    end

    // Everything reads as zero while reset is held, FETCH included
    assign PCsrc     = rst ? w_pcsrc    : 2'b00;
    assign IorD      = rst ? w_iord     : 1'b0;
    assign MemWrite  = rst ? w_memwrite : 1'b0;
    assign MemRead   = rst ? w_memread  : 1'b0;
    assign IRwrite   = rst ? w_irwrite  : 1'b0;
    assign RegDst    = rst ? w_regdst   : 1'b0;
    assign RegWrite  = rst ? w_regwrite : 1'b0;
    assign ALUsrcA   = rst ? w_alusrca  : 1'b0;
    assign ALUsrcB   = rst ? w_alusrcb  : 3'b000;
    assign ALUdir    = rst ? w_aludir   : 2'b00;
    assign MemToReg  = rst ? w_memtoreg : 1'b0;
    assign PCWrite   = rst ? w_pcwrite  : 1'b0;
    assign branch    = rst ? w_branch   : 1'b0;
    assign be        = rst ? w_be       : 1'b0;
    assign cur_state = rst ? r_state    : 4'd0;
    assign done_sig  = rst ? w_done     : 1'b0;

endmodule

// File: tb/tb_mips16_control_fsm.sv
// Self-checking bench for mips16_control_fsm: vector table, random instruction stream, reset/HALT sequences.
module tb_mips16_control_fsm;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic [3:0] funct;
    logic [1:0] PCsrc;
    logic       IorD, MemWrite, MemRead, IRwrite, RegDst, RegWrite, ALUsrcA;
    logic [2:0] ALUsrcB;
    logic [1:0] ALUdir;
    logic       MemToReg, PCWrite, branch, be;
    logic [3:0] cur_state;
    logic       done_sig;

    typedef struct packed {
        logic [1:0] pcsrc;
        logic       iord;
        logic       memwrite;
        logic       memread;
        logic       irwrite;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [2:0] alusrcb;
        logic [1:0] aludir;
        logic       memtoreg;
        logic       pcwrite;
        logic       branch;
        logic       be;
        logic       done;
    } outs_t;

    typedef struct {
        logic [3:0] op;
        logic [3:0] fn;
        int         lat;
    } vec_t;

    outs_t dut_o;
    int    checks = 0;
    int    errors = 0;
    int    exp_q[$];
    vec_t  vecs[16];

    mips16_control_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .PCsrc(PCsrc), .IorD(IorD), .MemWrite(MemWrite), .MemRead(MemRead),
        .IRwrite(IRwrite), .RegDst(RegDst), .RegWrite(RegWrite), .ALUsrcA(ALUsrcA),
        .ALUsrcB(ALUsrcB), .ALUdir(ALUdir), .MemToReg(MemToReg), .PCWrite(PCWrite),
        .branch(branch), .be(be), .cur_state(cur_state), .done_sig(done_sig)
    );

    assign dut_o = {PCsrc, IorD, MemWrite, MemRead, IRwrite, RegDst, RegWrite, ALUsrcA,
                    ALUsrcB, ALUdir, MemToReg, PCWrite, branch, be, done_sig};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected outputs per state, straight from the state table
    function automatic outs_t exp_out(input int st, input logic [3:0] op, input logic [3:0] fn);
        outs_t o;
        o = '0;
        case (st)
            0:  begin o.memread = 1'b1; o.irwrite = 1'b1; o.pcwrite = 1'b1; o.pcsrc = 2'b10; o.alusrcb = 3'b001; end
            1:  o.alusrcb = 3'b010;
            2:  begin o.alusrca = 1'b1; o.aludir = 2'b10; end
            3:  begin
                    o.regwrite = !(op == 4'b1000 && fn == 4'b0000);
                    o.regdst   = (op == 4'b0001 || op == 4'b0010);
                    o.done     = 1'b1;
                end
            4:  begin o.alusrca = 1'b1; o.alusrcb = 3'b011; o.aludir = 2'b10; end
            5:  begin o.alusrca = 1'b1; o.alusrcb = 3'b100; o.aludir = 2'b11; end
            6:  begin o.alusrca = 1'b1; o.alusrcb = 3'b100; end
            7:  begin o.memread = 1'b1; o.iord = 1'b1; end
            8:  begin o.memtoreg = 1'b1; o.regwrite = 1'b1; o.done = 1'b1; end
            9:  begin o.memwrite = 1'b1; o.iord = 1'b1; o.done = 1'b1; end
            10: begin o.alusrca = 1'b1; o.aludir = 2'b01; o.branch = 1'b1; o.be = ~op[0]; o.done = 1'b1; end
            11: begin o.pcwrite = 1'b1; o.done = 1'b1; end
            12: begin o.pcwrite = 1'b1; o.pcsrc = 2'b01; o.done = 1'b1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    // Instruction class -> list of states visited, FETCH through the done cycle
    function automatic void build_path(input logic [3:0] op, input logic [3:0] fn);
        int cls;
        exp_q = '{0, 1};
        if (op == 4'd8 && fn == 4'd0)                       cls = 0;
        else if (op inside {4'd8, 4'd12, 4'd1, 4'd2})       cls = 1;
        else if (op == 4'd11)                               cls = 2;
        else if (op inside {4'd9, 4'd10, 4'd6, 4'd7})       cls = 3;
        else if (op == 4'd13)                               cls = 4;
        else if (op == 4'd14)                               cls = 5;
        else if (op inside {4'd4, 4'd5})                    cls = 6;
        else if (op == 4'd3)                                cls = 7;
        else if (op == 4'd0)                                cls = 8;
`ifdef CTRL_HALT_EN
        else                                                cls = 9;
`else
        else                                                cls = 1;
`endif
        case (cls)
            0: exp_q.push_back(3);
            1: begin exp_q.push_back(2); exp_q.push_back(3); end
            2: begin exp_q.push_back(4); exp_q.push_back(3); end
            3: begin exp_q.push_back(5); exp_q.push_back(3); end
            4: begin exp_q.push_back(6); exp_q.push_back(7); exp_q.push_back(8); end
            5: begin exp_q.push_back(6); exp_q.push_back(9); end
            6: exp_q.push_back(10);
            7: exp_q.push_back(11);
            8: exp_q.push_back(12);
            default: exp_q.push_back(13);
        endcase
    endfunction

    task automatic check_cycle(input int st, input logic [3:0] op, input logic [3:0] fn, input string tag);
        outs_t e;
        e = exp_out(st, op, fn);
        chk({tag, "_state"}, {28'd0, cur_state}, st);
        chk({tag, "_outs"}, {13'd0, dut_o}, {13'd0, e});
        chk({tag, "_mem_excl"}, {31'd0, MemRead & MemWrite}, 32'd0);
        chk({tag, "_pc_excl"}, {31'd0, PCWrite & branch}, 32'd0);
    endtask

    // Entered at posedge+1 with the DUT in FETCH; leaves it back in FETCH
    task automatic run_instr(input logic [3:0] op, input logic [3:0] fn, input int exp_lat, input string tag);
        int lat;
        int dones;
        lat   = 0;
        dones = 0;
        opcode = op;
        funct  = fn;
        build_path(op, fn);
        if (exp_lat < 0) exp_lat = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check_cycle(exp_q[i], op, fn, tag);
            if (done_sig) begin
                dones++;
                if (lat == 0) lat = i + 1;
            end
            @(posedge clk);
            #1;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_done_count"}, dones, 1);
    endtask

    initial begin
        vecs[0]  = '{4'b1000, 4'b0001, 4};
        vecs[1]  = '{4'b1101, 4'b0000, 5};
        vecs[2]  = '{4'b0101, 4'b0000, 3};
        vecs[3]  = '{4'b0100, 4'b0000, 3};
        vecs[4]  = '{4'b0000, 4'b0000, 3};
        vecs[5]  = '{4'b0010, 4'b0000, 4};
        vecs[6]  = '{4'b1011, 4'b0011, 4};
        vecs[7]  = '{4'b1001, 4'b0000, 4};
        vecs[8]  = '{4'b1110, 4'b0000, 4};
        vecs[9]  = '{4'b0011, 4'b0000, 3};
        vecs[10] = '{4'b1000, 4'b0000, 3};
        vecs[11] = '{4'b0001, 4'b0111, 4};
        vecs[12] = '{4'b1100, 4'b0010, 4};
        vecs[13] = '{4'b0110, 4'b0000, 4};
        vecs[14] = '{4'b0111, 4'b1111, 4};
        vecs[15] = '{4'b1010, 4'b0101, 4};

        rst    = 1'b0;
        opcode = 4'd0;
        funct  = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outs", {13'd0, dut_o}, 32'd0);
            chk("reset_state", {28'd0, cur_state}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_instr(vecs[i].op, vecs[i].fn, vecs[i].lat, $sformatf("vec%0d", i));
        end
`ifndef CTRL_HALT_EN
        run_instr(4'b1111, 4'b0000, 4, "op15_rtype");
`endif

        // Reset asserted from MADDR aborts the load
        opcode = 4'b1101;
        funct  = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_state", {28'd0, cur_state}, 32'd0);
        chk("midrst_outs", {13'd0, dut_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        run_instr(4'b1000, 4'b0011, 4, "after_midrst");

`ifdef CTRL_HALT_EN
        opcode = 4'b1111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_cycle(13, 4'b1111, 4'b0000, "halt");
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        chk("halt_rst_state", {28'd0, cur_state}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        run_instr(4'b0100, 4'b0000, 3, "after_halt");
`endif

        for (int k = 0; k < 60; k++) begin
            logic [3:0] rop;
            logic [3:0] rfn;
            rop = 4'($urandom_range(0, 15));
            rfn = (k % 7 == 0) ? 4'd0 : 4'($urandom_range(0, 15));
`ifdef CTRL_HALT_EN
            if (rop == 4'd15) rop = 4'd8;
`endif
            run_instr(rop, rfn, -1, $sformatf("rand%0d_op%0h", k, rop));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
